lcd_timing_ctrl: RTL and testbench

//  Raster timing sequencer for the LCD output stage, clocked by the pixel clock.

---
 rtl/lcd_timing_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - raster timing sequencer for the LCD output stage
// Generates sync, active qualifier, STN read / TFT request, frame sequencing and underflow.
module lcd_timing_ctrl #(
  parameter int HW = 10,
  parameter int VW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          tft,
  input  logic [HW-1:0] ppl,
  input  logic [HW-1:0] hsw,
  input  logic [HW-1:0] hbp,
  input  logic [HW-1:0] hfp,
  input  logic [VW-1:0] lpp,
  input  logic [VW-1:0] vsw,
  input  logic [VW-1:0] vbp,
  input  logic [VW-1:0] vfp,
  input  logic          ihs,
  input  logic          ivs,
  input  logic          stn_empty,
  input  logic          clr_unf,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          read,
  output logic          tft_req,
  output logic          frame_done,
  output logic          underflow,
  output logic          busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] PH_SYNC = 2'd0;
  localparam logic [1:0] PH_BP   = 2'd1;
  localparam logic [1:0] PH_ACT  = 2'd2;
  localparam logic [1:0] PH_FP   = 2'd3;

  localparam logic [HW-1:0] HONE = 1;
  localparam logic [VW-1:0] VONE = 1;

  logic [0:0]    state, nstate;
  logic [1:0]    hph, vph, nhph, nvph;
  logic [HW-1:0] hcnt, nhcnt, hlen;
  logic [VW-1:0] vcnt, nvcnt, vlen;
  logic [HW-1:0] ppl_s, hsw_s, hbp_s, hfp_s;
  logic [VW-1:0] lpp_s, vsw_s, vbp_s, vfp_s;
  logic          ihs_s, ivs_s, tft_s;
  logic          hs_q, vs_q, act_q, fd_q, unf_q;
  logic          h_last, v_last, load, run_n;

  always_comb begin
    case (hph)
      PH_SYNC: hlen = hsw_s;
      PH_BP:   hlen = hbp_s;
      PH_ACT:  hlen = ppl_s;
      default: hlen = hfp_s;
    endcase
    case (vph)
      PH_SYNC: vlen = vsw_s;
      PH_BP:   vlen = vbp_s;
      PH_ACT:  vlen = lpp_s;
      default: vlen = vfp_s;
    endcase
    h_last = (hcnt == hlen);
    v_last = (vcnt == vlen);

    nstate = state;
    nhph   = hph;
    nvph   = vph;
    nhcnt  = hcnt;
    nvcnt  = vcnt;
    if (state == IDLE) begin
      nhph  = PH_SYNC;
      nvph  = PH_SYNC;
      nhcnt = '0;
      nvcnt = '0;
      if (enable) nstate = RUN;
    end else begin
      if (h_last) begin
        nhcnt = '0;
        nhph  = hph + 2'd1;
      end else begin
        nhcnt = hcnt + HONE;
      end
      if (h_last && hph == PH_FP) begin
        if (v_last) begin
          nvcnt = '0;
          nvph  = vph + 2'd1;
        end else begin
          nvcnt = vcnt + VONE;
        end
      end
      // The last frame position wraps naturally to the first; only the FSM decides to stop.
      if (fd_q && !enable) nstate = IDLE;
    end

    load  = ((state == IDLE) && enable) || fd_q;
    run_n = (nstate == RUN);
  end

  // Output flops are loaded from the next position so they line up with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hph   <= PH_SYNC;
      vph   <= PH_SYNC;
      hcnt  <= '0;
      vcnt  <= '0;
      ppl_s <= '0;
      hsw_s <= '0;
      hbp_s <= '0;
      hfp_s <= '0;
      lpp_s <= '0;
      vsw_s <= '0;
      vbp_s <= '0;
      vfp_s <= '0;
      ihs_s <= 1'b0;
      ivs_s <= 1'b0;
      tft_s <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      act_q <= 1'b0;
      fd_q  <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state <= nstate;
      hph   <= nhph;
      vph   <= nvph;
      hcnt  <= nhcnt;
      vcnt  <= nvcnt;
      if (load) begin
        ppl_s <= ppl;
        hsw_s <= hsw;
        hbp_s <= hbp;
        hfp_s <= hfp;
        lpp_s <= lpp;
        vsw_s <= vsw;
        vbp_s <= vbp;
        vfp_s <= vfp;
        ihs_s <= ihs;
        ivs_s <= ivs;
        tft_s <= tft;
      end
      hs_q  <= run_n && (nhph == PH_SYNC);
      vs_q  <= run_n && (nvph == PH_SYNC);
      act_q <= run_n && (nhph == PH_ACT) && (nvph == PH_ACT);
      fd_q  <= run_n && (nhph == PH_FP) && (nhcnt == hfp_s) &&
               (nvph == PH_FP) && (nvcnt == vfp_s);
      if (read && stn_empty) unf_q <= 1'b1;
      else if (clr_unf)      unf_q <= 1'b0;
    end
  end

  // Idle polarity follows the live ihs/ivs so the inactive level is correct straight out of reset.
  assign busy       = (state == RUN);
  assign hsync      = hs_q ^ (busy ? ihs_s : ihs);
  assign vsync      = vs_q ^ (busy ? ivs_s : ivs);
  assign active     = act_q;
  assign read       = act_q & ~tft_s;
  assign tft_req    = act_q & tft_s;
  assign frame_done = fd_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb/tb_lcd_timing_ctrl.sv - self-checking bench for lcd_timing_ctrl
`timescale 1ns/1ps
module tb_lcd_timing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       tft = 1'b0;
  logic [9:0] ppl = '0, hsw = '0, hbp = '0, hfp = '0;
  logic [9:0] lpp = '0, vsw = '0, vbp = '0, vfp = '0;
  logic       ihs = 1'b0, ivs = 1'b0, stn_empty = 1'b0, clr_unf = 1'b0;
  logic       hsync, vsync, active, read, tft_req, frame_done, underflow, busy;

  lcd_timing_ctrl #(.HW(10), .VW(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tft(tft),
    .ppl(ppl), .hsw(hsw), .hbp(hbp), .hfp(hfp),
    .lpp(lpp), .vsw(vsw), .vbp(vbp), .vfp(vfp),
    .ihs(ihs), .ivs(ivs), .stn_empty(stn_empty), .clr_unf(clr_unf),
    .hsync(hsync), .vsync(vsync), .active(active), .read(read),
    .tft_req(tft_req), .frame_done(frame_done), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ppl, hsw, hbp, hfp, lpp, vsw, vbp, vfp;
    logic       tft, ihs, ivs;
    int         exp_len;
    int         exp_req;
  } vec_t;

  typedef struct {
    logic [7:0] word;
    string      tag;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_cur;
  logic [7:0] got_w;
  int         nvec = 0, nerr = 0;
  int         busy_cnt = 0, req_cnt = 0, fd_cnt = 0;
  logic       exp_unf = 1'b0;
  vec_t       tbl[5];
  vec_t       v5;

  // word layout: {hsync, vsync, active, read, tft_req, frame_done, busy, underflow}
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_cur = sb.pop_front();
      got_w = {hsync, vsync, active, read, tft_req, frame_done, busy, underflow};
      nvec++;
      if (got_w !== e_cur.word) begin
        nerr++;
        $display("FAIL %s cyc %0d: got %b want %b (hs vs act rd treq fd busy unf)",
                 e_cur.tag, e_cur.cyc, got_w, e_cur.word);
      end
    end
    busy_cnt += int'(busy);
    req_cnt  += int'(read | tft_req);
    fd_cnt   += int'(frame_done);
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int flen(input vec_t c);
    return (int'(c.hsw) + int'(c.hbp) + int'(c.ppl) + int'(c.hfp) + 4) *
           (int'(c.vsw) + int'(c.vbp) + int'(c.lpp) + int'(c.vfp) + 4);
  endfunction

  // Raster model from the frame-relative cycle number k.
  function automatic logic [7:0] model(input vec_t c, input int k, input logic unf);
    int   hw_, hb_, pp_, hf_, vw_, vb_, lp_, vf_, l_len, n_lines, x, y;
    logic hs, vs, act, fd;
    hw_ = int'(c.hsw); hb_ = int'(c.hbp); pp_ = int'(c.ppl); hf_ = int'(c.hfp);
    vw_ = int'(c.vsw); vb_ = int'(c.vbp); lp_ = int'(c.lpp); vf_ = int'(c.vfp);
    l_len   = hw_ + hb_ + pp_ + hf_ + 4;
    n_lines = vw_ + vb_ + lp_ + vf_ + 4;
    x   = k % l_len;
    y   = k / l_len;
    hs  = (x <= hw_);
    vs  = (y <= vw_);
    act = (x >= hw_ + hb_ + 2) && (x <= hw_ + hb_ + pp_ + 2) &&
          (y >= vw_ + vb_ + 2) && (y <= vw_ + vb_ + lp_ + 2);
    fd  = (k == l_len * n_lines - 1);
    return {hs ^ c.ihs, vs ^ c.ivs, act, act & ~c.tft, act & c.tft, fd, 1'b1, unf};
  endfunction

  function automatic logic [7:0] idle_w(input vec_t c, input logic unf);
    return {c.ihs, c.ivs, 5'b00000, unf};
  endfunction

  task automatic apply(input vec_t c);
    ppl = c.ppl; hsw = c.hsw; hbp = c.hbp; hfp = c.hfp;
    lpp = c.lpp; vsw = c.vsw; vbp = c.vbp; vfp = c.vfp;
    tft = c.tft; ihs = c.ihs; ivs = c.ivs;
  endtask

  task automatic push(input logic [7:0] w, input string tag, input int cyc);
    exp_t e;
    e.word = w;
    e.tag  = tag;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  // Starts from IDLE at posedge+1; c2 is driven from cycle chg_at of frame 0 and shadows in from frame 1.
  task automatic run(input vec_t c, input vec_t c2, input int nfr, input int chg_at,
                     input int drop_at, input int empty_at, input int clr_at, input string tag);
    vec_t       m;
    logic [7:0] w;
    apply(c);
    enable = 1'b1;
    busy_cnt = 0; req_cnt = 0; fd_cnt = 0;
    push(idle_w(c, exp_unf), tag, -1);
    @(posedge clk); #1;
    for (int f = 0; f < nfr; f++) begin
      m = (f == 0) ? c : c2;
      for (int k = 0; k < flen(m); k++) begin
        if (f == 0 && k == chg_at) apply(c2);
        if (f == nfr - 1 && k == drop_at) enable = 1'b0;
        stn_empty = (f == 0 && k == empty_at);
        clr_unf   = (f == 0 && k == clr_at);
        w = model(m, k, exp_unf);
        push(w, tag, f * 100000 + k);
        if (w[4] && stn_empty) exp_unf = 1'b1;
        else if (clr_unf)      exp_unf = 1'b0;
        @(posedge clk); #1;
      end
    end
    stn_empty = 1'b0;
    clr_unf   = 1'b0;
    repeat (3) begin
      push(idle_w(c2, exp_unf), tag, -2);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            ppl    hsw    hbp    hfp     lpp    vsw    vbp    vfp   tft  ihs  ivs  len   req
    tbl[0] = '{10'd3, 10'd0, 10'd1, 10'd0,   10'd1, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 40,   8};
    tbl[1] = '{10'd3, 10'd0, 10'd1, 10'd0,   10'd1, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 40,   8};
    tbl[2] = '{10'd3, 10'd0, 10'd1, 10'd0,   10'd1, 10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 40,   8};
    tbl[3] = '{10'd5, 10'd1, 10'd0, 10'd2,   10'd2, 10'd1, 10'd1, 10'd0, 1'b1, 1'b0, 1'b1, 96,   18};
    tbl[4] = '{10'd3, 10'd0, 10'd1, 10'h3FF, 10'd1, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 5155, 8};

    // reset state, including idle polarity tracking ihs/ivs
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {hsync, vsync, active, read, tft_req, frame_done, busy, underflow}, 8'h00);
    ihs = 1'b1; ivs = 1'b1;
    #1;
    chk("reset_polarity", {6'b0, hsync, vsync}, 8'h03);
    ihs = 1'b0; ivs = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      int nfr;
      nfr = (i == 0) ? 2 : 1;
      run(tbl[i], tbl[i], nfr, -1, 0, -1, -1, $sformatf("vec%0d", i));
      chk_int($sformatf("vec%0d_busy_cycles", i), busy_cnt, tbl[i].exp_len * nfr);
      chk_int($sformatf("vec%0d_requests", i), req_cnt, tbl[i].exp_req * nfr);
      chk_int($sformatf("vec%0d_frame_done", i), fd_cnt, nfr);
    end

    // underflow set, hold, clear, and set winning over a coincident clear
    run(tbl[1], tbl[1], 1, -1, 0, 19, -1, "unf_set");
    chk("unf_held", {7'b0, underflow}, 8'h01);
    clr_unf = 1'b1;
    @(posedge clk); #1;
    clr_unf = 1'b0;
    exp_unf = 1'b0;
    chk("unf_cleared", {7'b0, underflow}, 8'h00);
    run(tbl[1], tbl[1], 1, -1, 0, 19, 19, "unf_set_wins");
    chk("unf_set_wins_end", {7'b0, underflow}, 8'h01);
    clr_unf = 1'b1;
    @(posedge clk); #1;
    clr_unf = 1'b0;
    exp_unf = 1'b0;

    // enable dropped at cycle 10: frame completes, then stays idle
    run(tbl[0], tbl[0], 1, -1, 10, -1, -1, "drop_mid");
    chk_int("drop_mid_busy_cycles", busy_cnt, 40);
    chk_int("drop_mid_frame_done", fd_cnt, 1);

    // ppl 3->7 mid-frame with inverted syncs: second frame uses 12-cycle lines
    v5 = tbl[2];
    v5.ppl = 10'd7;
    run(tbl[2], v5, 2, 5, 0, -1, -1, "shadow");
    chk_int("shadow_busy_cycles", busy_cnt, 40 + 60);
    chk_int("shadow_requests", req_cnt, 8 + 16);
    chk_int("shadow_frame_done", fd_cnt, 2);

    // reset asserted during an active pixel
    apply(tbl[0]);
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    #1;
    chk("rst_mid_pre", {6'b0, active, busy}, 8'h03);
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {hsync, vsync, active, read, tft_req, frame_done, busy, underflow}, 8'h00);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_unf = 1'b0;
    @(posedge clk); #1;
    run(tbl[0], tbl[0], 1, -1, 0, -1, -1, "after_reset");
    chk_int("after_reset_busy_cycles", busy_cnt, 40);
    chk_int("after_reset_requests", req_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
